// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory. Port 0 (CPU load/store) has fixed priority; port 1 (DMA/debug) is
// protected from starvation by a saturating wait counter. Every granted
// request is checked for word alignment and range before memory is touched.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   p0_req/wr/addr/wdata       port 0 request (held until p0_ack)
//   p0_ack/rdata/err           port 0 completion pulse, load data, error flag
//   p1_*                       same for port 1
//   mem_en/wr/addr/wdata       memory strobe (one cycle per access) and command
//   mem_rdata                  memory read data, valid the cycle after mem_en
//   busy                       high whenever the sequencer is not idle
//   owner                      current grant (0=port 0, 1=port 1) while busy
module dm_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 12288,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0]  WAIT_MAX  = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rd_sel;   // RESP cycle returns mem_rdata (legal load)

    logic              grant1;
    logic              g_wr;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_legal;

    always_comb begin
        grant1  = p1_req && (!p0_req || (wait_cnt == WAIT_MAX));
        g_wr    = grant1 ? p1_wr    : p0_wr;
        g_addr  = grant1 ? p1_addr  : p0_addr;
        g_wdata = grant1 ? p1_wdata : p0_wdata;
        g_legal = (g_addr[1:0] == 2'b00) && (g_addr <= LAST_WORD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            rd_sel <= 1'b0;

            // Port 1 accrues waiting time unless it is the one being served;
            // a port-1 grant below overrides this with a clear.
            if (p1_req && !(busy && owner) && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        busy  <= 1'b1;
                        owner <= grant1;
                        if (grant1)
                            wait_cnt <= '0;
                        if (g_legal) begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_wr    <= g_wr;
                            mem_addr  <= g_addr;
                            mem_wdata <= g_wdata;
                        end else begin
                            // Rejected requests skip the memory entirely.
                            state  <= RESP;
                            p0_ack <= !grant1;
                            p1_ack <= grant1;
                            p0_err <= !grant1;
                            p1_err <= grant1;
                        end
                    end
                end
                ACCESS: begin
                    state  <= RESP;
                    p0_ack <= !owner;
                    p1_ack <= owner;
                    rd_sel <= !mem_wr;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Load data arrives from memory during RESP, so it is steered straight
    // through, gated by registered ack/rd_sel.
    always_comb begin
        p0_rdata = (p0_ack && rd_sel) ? mem_rdata : '0;
        p1_rdata = (p1_ack && rd_sel) ? mem_rdata : '0;
    end

endmodule
